// File: rtl/ibex_ibus_arb_pkg.sv
// Shared types and limits for the instruction-bus arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ibex_ibus_arb_pkg;

    localparam int unsigned NumHosts            = 2;
    localparam int unsigned PerfCntW            = 16;
    localparam int unsigned MaxOutstandingLimit = 4;

    // Sized for the largest supported queue so the FIFO ports never change width.
    localparam int unsigned CntW = $clog2(MaxOutstandingLimit + 1);
    localparam int unsigned PtrW = $clog2(MaxOutstandingLimit);

    typedef logic host_id_t;

    function automatic logic [NumHosts-1:0] host_onehot(input host_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ibex_ibus_arb_id_fifo.sv
// Circular queue of host IDs for granted-but-unanswered device transactions.
// Latency: head_o/count_o reflect registered state; a push is visible the next cycle.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/push_id_i enqueue,
// pop_i dequeue; count_o entries held; head_o ID of the oldest entry.
module ibex_ibus_arb_id_fifo
    import ibex_ibus_arb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  host_id_t        push_id_i,
    input  logic            pop_i,
    output logic [CntW-1:0] count_o,
    output host_id_t        head_o
);

    host_id_t        mem_q [MaxOutstandingLimit];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign do_push = push_i & (count_q != CntW'(Depth));
    assign do_pop  = pop_i  & (count_q != '0);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only read while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ibex_ibus_arbiter.sv
// Two-host req/gnt/rvalid arbiter sharing one instruction memory port; rvalids are routed by an ID queue.
// Latency: zero added cycles on req->gnt and rvalid paths (combinational routing).
// Backpressure: device gnt passes through; dev_req_o is withheld while MaxOutstanding answers are pending.
//
// Ports: host_req_i/host_addr_i/host_gnt_o/host_rvalid_o per host, host_rdata_o/host_err_o broadcast;
// dev_* single device port; busy_o activity flag; perf_gnt_cnt_o per-host grant counters.
// Optional macro IBUS_ARB_PERF_EN: builds saturating grant counters, otherwise perf_gnt_cnt_o is tied to zero.
module ibex_ibus_arbiter
    import ibex_ibus_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RoundRobin     = 1'b1,
    parameter bit          ResetAll       = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumHosts-1:0]                host_req_i,
    input  logic [NumHosts-1:0][31:0]          host_addr_i,
    output logic [NumHosts-1:0]                host_gnt_o,
    output logic [NumHosts-1:0]                host_rvalid_o,
    output logic [31:0]                        host_rdata_o,
    output logic                               host_err_o,
    output logic                               dev_req_o,
    input  logic                               dev_gnt_i,
    output logic [31:0]                        dev_addr_o,
    input  logic                               dev_rvalid_i,
    input  logic [31:0]                        dev_rdata_i,
    input  logic                               dev_err_i,
    output logic                               busy_o,
    output logic [NumHosts-1:0][PerfCntW-1:0]  perf_gnt_cnt_o
);

    if (MaxOutstanding < 1 || MaxOutstanding > MaxOutstandingLimit) begin : g_bad_cfg
        $error("ibex_ibus_arbiter: MaxOutstanding out of range 1..4");
    end

    host_id_t        sel, lock_id_q, prio_q, head_id;
    logic            lock_q, full, granted;
    logic [CntW-1:0] count;

    // A request left waiting for gnt pins the selection so its address stays stable.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (RoundRobin) begin
            sel = host_req_i[prio_q] ? prio_q : ~prio_q;
        end else begin
            sel = host_req_i[0] ? 1'b0 : 1'b1;
        end
    end

    // Registered state only, so there is no rvalid->req combinational path.
    assign full       = (count == CntW'(MaxOutstanding));
    assign dev_req_o  = host_req_i[sel] & ~full;
    assign dev_addr_o = host_addr_i[sel];
    assign granted    = dev_req_o & dev_gnt_i;
    assign host_gnt_o = granted ? host_onehot(sel) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            // Clears on grant, and also if the locked host illegally withdraws.
            lock_q <= dev_req_o & ~dev_gnt_i;
            if (dev_req_o & ~dev_gnt_i) lock_id_q <= sel;
            if (granted)                prio_q    <= ~sel;
        end
    end

    ibex_ibus_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (granted),
        .push_id_i (sel),
        .pop_i     (dev_rvalid_i),
        .count_o   (count),
        .head_o    (head_id)
    );

    // Responses with no owner (e.g. to grants issued before a reset) are dropped here.
    assign host_rvalid_o = (dev_rvalid_i && count != '0) ? host_onehot(head_id) : '0;
    assign host_rdata_o  = dev_rdata_i;
    assign host_err_o    = dev_err_i;
    assign busy_o        = (count != '0) | dev_req_o;

`ifdef IBUS_ARB_PERF_EN
    for (genvar i = 0; i < NumHosts; i++) begin : g_perf
        logic [PerfCntW-1:0] cnt_q;
        logic                cnt_inc;
        assign cnt_inc = host_gnt_o[i] & (cnt_q != '1);
        if (ResetAll) begin : g_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)      cnt_q <= '0;
                else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            end
        end else begin : g_nrst
            always_ff @(posedge clk_i) begin
                if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            end
        end
        assign perf_gnt_cnt_o[i] = cnt_q;
    end
`else
    logic unused_reset_all;
    assign unused_reset_all = ResetAll;
    assign perf_gnt_cnt_o   = '0;
`endif

    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dev_rvalid_i |-> (count != '0));

    a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> host_req_i[lock_id_q]);

endmodule

// File: tb/tb_ibex_ibus_arbiter.sv
module tb_ibex_ibus_arbiter;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [1:0]        host_req_i;
    logic [1:0][31:0]  host_addr_i;
    logic              dev_gnt_i, dev_rvalid_i, dev_err_i;
    logic [31:0]       dev_rdata_i;

    logic [1:0]        host_gnt_o, host_rvalid_o, fp_gnt_o, fp_rvalid_o;
    logic [31:0]       host_rdata_o, dev_addr_o, fp_rdata_o, fp_addr_o;
    logic              host_err_o, dev_req_o, busy_o, fp_err_o, fp_req_o, fp_busy_o;
    logic [1:0][15:0]  perf_o, fp_perf_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ibex_ibus_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b1), .ResetAll(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .host_req_i(host_req_i), .host_addr_i(host_addr_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o), .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i),
        .dev_addr_o(dev_addr_o), .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
        .dev_err_i(dev_err_i), .busy_o(busy_o), .perf_gnt_cnt_o(perf_o));

    ibex_ibus_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b0), .ResetAll(1'b1)) dut_fp (
        .clk_i(clk_i), .rst_ni(rst_ni), .host_req_i(host_req_i), .host_addr_i(host_addr_i),
        .host_gnt_o(fp_gnt_o), .host_rvalid_o(fp_rvalid_o), .host_rdata_o(fp_rdata_o),
        .host_err_o(fp_err_o), .dev_req_o(fp_req_o), .dev_gnt_i(dev_gnt_i),
        .dev_addr_o(fp_addr_o), .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
        .dev_err_i(dev_err_i), .busy_o(fp_busy_o), .perf_gnt_cnt_o(fp_perf_o));

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0, a1;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_req;
        logic [31:0] e_addr;
        logic [1:0]  e_gnt, e_gnt_fp, e_rv;
        logic        e_busy;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic err, input logic e_req, input logic [31:0] e_addr,
                                input logic [1:0] e_gnt, input logic [1:0] e_gnt_fp,
                                input logic [1:0] e_rv, input logic e_busy);
        vec_t v;
        v.req = req; v.a0 = a0; v.a1 = a1; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
        v.e_req = e_req; v.e_addr = e_addr; v.e_gnt = e_gnt; v.e_gnt_fp = e_gnt_fp;
        v.e_rv = e_rv; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic gnt, input logic rv, input logic [31:0] rdata, input logic err);
        host_req_i     = req;
        host_addr_i[0] = a0;
        host_addr_i[1] = a1;
        dev_gnt_i      = gnt;
        dev_rvalid_i   = rv;
        dev_rdata_i    = rdata;
        dev_err_i      = err;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [15:0] exp_c0, exp_c1;

        // Single grant/response, round-robin alternation, lock, full stall and drain.
        vecs[0]  = mk(2'b01, 32'h100, 32'h0,   1, 0, 32'h0,        0, 1, 32'h100, 2'b01, 2'b01, 2'b00, 1);
        vecs[1]  = mk(2'b00, 32'h0,   32'h0,   0, 0, 32'h0,        0, 0, 32'h0,   2'b00, 2'b00, 2'b00, 1);
        vecs[2]  = mk(2'b00, 32'h0,   32'h0,   0, 1, 32'hDEADBEEF, 0, 0, 32'h0,   2'b00, 2'b00, 2'b01, 1);
        vecs[3]  = mk(2'b00, 32'h0,   32'h0,   0, 0, 32'h0,        0, 0, 32'h0,   2'b00, 2'b00, 2'b00, 0);
        vecs[4]  = mk(2'b11, 32'h400, 32'h500, 1, 0, 32'h0,        0, 1, 32'h500, 2'b10, 2'b01, 2'b00, 1);
        vecs[5]  = mk(2'b11, 32'h400, 32'h500, 1, 1, 32'h11,       0, 1, 32'h400, 2'b01, 2'b01, 2'b10, 1);
        vecs[6]  = mk(2'b11, 32'h400, 32'h500, 1, 1, 32'h22,       0, 1, 32'h500, 2'b10, 2'b01, 2'b01, 1);
        vecs[7]  = mk(2'b11, 32'h400, 32'h500, 1, 1, 32'h33,       0, 1, 32'h400, 2'b01, 2'b01, 2'b10, 1);
        vecs[8]  = mk(2'b00, 32'h0,   32'h0,   0, 1, 32'h44,       0, 0, 32'h0,   2'b00, 2'b00, 2'b01, 1);
        vecs[9]  = mk(2'b01, 32'h200, 32'h300, 0, 0, 32'h0,        0, 1, 32'h200, 2'b00, 2'b00, 2'b00, 1);
        vecs[10] = mk(2'b11, 32'h200, 32'h300, 0, 0, 32'h0,        0, 1, 32'h200, 2'b00, 2'b00, 2'b00, 1);
        vecs[11] = mk(2'b11, 32'h200, 32'h300, 0, 0, 32'h0,        0, 1, 32'h200, 2'b00, 2'b00, 2'b00, 1);
        vecs[12] = mk(2'b11, 32'h200, 32'h300, 1, 0, 32'h0,        0, 1, 32'h200, 2'b01, 2'b01, 2'b00, 1);
        vecs[13] = mk(2'b10, 32'h200, 32'h300, 1, 0, 32'h0,        0, 1, 32'h300, 2'b10, 2'b10, 2'b00, 1);
        vecs[14] = mk(2'b11, 32'h600, 32'h300, 1, 0, 32'h0,        0, 0, 32'h600, 2'b00, 2'b00, 2'b00, 1);
        vecs[15] = mk(2'b11, 32'h600, 32'h300, 1, 1, 32'h55,       1, 0, 32'h600, 2'b00, 2'b00, 2'b01, 1);
        vecs[16] = mk(2'b11, 32'h600, 32'h300, 1, 0, 32'h0,        0, 1, 32'h600, 2'b01, 2'b01, 2'b00, 1);
        vecs[17] = mk(2'b00, 32'h0,   32'h0,   0, 1, 32'h66,       0, 0, 32'h0,   2'b00, 2'b00, 2'b10, 1);
        vecs[18] = mk(2'b00, 32'h0,   32'h0,   0, 1, 32'h77,       0, 0, 32'h0,   2'b00, 2'b00, 2'b01, 1);
        vecs[19] = mk(2'b00, 32'h0,   32'h0,   0, 0, 32'h0,        0, 0, 32'h0,   2'b00, 2'b00, 2'b00, 0);

        // Reset state.
        rst_ni = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        tick();
        tick();
        check("reset dev_req", {31'b0, dev_req_o}, 32'h0);
        check("reset host_gnt", {30'b0, host_gnt_o}, 32'h0);
        check("reset host_rvalid", {30'b0, host_rvalid_o}, 32'h0);
        check("reset busy", {31'b0, busy_o}, 32'h0);
        check("reset perf0", {16'b0, perf_o[0]}, 32'h0);
        check("reset perf1", {16'b0, perf_o[1]}, 32'h0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].err);
            #2;
            check($sformatf("row%0d dev_req", i),    {31'b0, dev_req_o},     {31'b0, vecs[i].e_req});
            check($sformatf("row%0d dev_addr", i),   dev_addr_o,             vecs[i].e_addr);
            check($sformatf("row%0d host_gnt", i),   {30'b0, host_gnt_o},    {30'b0, vecs[i].e_gnt});
            check($sformatf("row%0d fixed_gnt", i),  {30'b0, fp_gnt_o},      {30'b0, vecs[i].e_gnt_fp});
            check($sformatf("row%0d host_rvalid", i), {30'b0, host_rvalid_o}, {30'b0, vecs[i].e_rv});
            check($sformatf("row%0d busy", i),       {31'b0, busy_o},        {31'b0, vecs[i].e_busy});
            check($sformatf("row%0d rdata", i),      host_rdata_o,           vecs[i].rdata);
            check($sformatf("row%0d err", i),        {31'b0, host_err_o},    {31'b0, vecs[i].err});
            tick();
        end

        // Reset with two outstanding grants; a late response must not reach a host.
        drive(2'b01, 32'h700, 32'h0, 1, 0, 32'h0, 0);
        tick();
        tick();
        check("pre-reset busy", {31'b0, busy_o}, 32'h1);
        check("pre-reset full stall", {31'b0, dev_req_o}, 32'h0);
        drive(2'b00, 32'h0, 32'h0, 0, 1, 32'hBAD, 0);
        rst_ni = 1'b0;
        #2;
        check("mid-reset busy", {31'b0, busy_o}, 32'h0);
        check("mid-reset rvalid", {30'b0, host_rvalid_o}, 32'h0);
        check("mid-reset fixed rvalid", {30'b0, fp_rvalid_o}, 32'h0);
        check("mid-reset gnt", {30'b0, host_gnt_o}, 32'h0);
        tick();
        check("reset stray rvalid", {30'b0, host_rvalid_o}, 32'h0);
        dev_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        #2;
        check("post-reset busy", {31'b0, busy_o}, 32'h0);
        tick();

        // Grant counters: three host1 grants, then 70000 host0 grants to hit saturation.
        drive(2'b10, 32'h0, 32'h800, 1, 0, 32'h0, 0);
        #2;
        check("perf host1 first gnt", {30'b0, host_gnt_o}, 32'h2);
        tick();
        drive(2'b10, 32'h0, 32'h800, 1, 1, 32'h0, 0);
        tick();
        tick();
        drive(2'b00, 32'h0, 32'h0, 0, 1, 32'h0, 0);
        tick();
        for (int k = 0; k < 70000; k++) begin
            drive(2'b01, 32'h900, 32'h0, 1, (k != 0), 32'h0, 0);
            tick();
        end
        drive(2'b00, 32'h0, 32'h0, 0, 1, 32'h0, 0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        #2;
`ifdef IBUS_ARB_PERF_EN
        exp_c0 = 16'hFFFF;
        exp_c1 = 16'd3;
`else
        exp_c0 = 16'h0;
        exp_c1 = 16'h0;
`endif
        check("perf host0 count", {16'b0, perf_o[0]}, {16'b0, exp_c0});
        check("perf host1 count", {16'b0, perf_o[1]}, {16'b0, exp_c1});
        check("perf fixed host0 count", {16'b0, fp_perf_o[0]}, {16'b0, exp_c0});
        check("perf fixed host1 count", {16'b0, fp_perf_o[1]}, {16'b0, exp_c1});
        check("final busy", {31'b0, busy_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
